// File: rtl/vector_exec_unit_if.sv
// Request/result bundle between a vector_exec_unit and its issuing pipeline.
// The master issues operations and consumes results; the slave is the execution unit.
interface vector_exec_unit_if #(
  parameter int LANES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [32*LANES-1:0]   src_a;
  logic [32*LANES-1:0]   src_b;
  logic [5:0]            dst;
  logic                  res_valid;
  logic                  res_ready;
  logic [32*LANES-1:0]   res_data;
  logic [5:0]            res_dst;
  logic                  res_we;

  modport master (
    output in_valid, op, src_a, src_b, dst, res_ready,
    input  in_ready, res_valid, res_data, res_dst, res_we
  );

  modport slave (
    input  in_valid, op, src_a, src_b, dst, res_ready,
    output in_ready, res_valid, res_data, res_dst, res_we
  );
endinterface

// File: rtl/vector_exec_unit.sv
// Multi-cycle vector ALU: one 32-bit lane per cycle, result held until the consumer accepts it.
// state | meaning
// IDLE  | ready for a request (in_ready = 1)
// BUSY  | computing lane r_cnt; scalar ops stop after lane 0
// DONE  | result valid, waiting for res_ready
module vector_exec_unit #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  vector_exec_unit_if.slave  bus
);
  localparam int W  = 32 * LANES;
  localparam int CW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_res_valid;
  logic            r_res_we;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res_data;
  logic [5:0]      r_dst;

  logic [CW+4:0]   w_lsb;
  logic [31:0]     w_a;
  logic [31:0]     w_b;
  logic [31:0]     w_lane;
  logic            w_last;

  assign w_lsb  = {r_cnt, 5'd0};
  assign w_a    = r_a[w_lsb +: 32];
  assign w_b    = r_b[w_lsb +: 32];
  // Scalar destinations (dst[5] = 0) only ever produce lane 0.
  assign w_last = !r_dst[5] || (r_cnt == CW'(LANES - 1));

  always_comb begin
    w_lane = '0;
    case (r_op)
      3'b000: w_lane = w_a + w_b;
      3'b001: w_lane = w_a - w_b;
      3'b010: w_lane = w_a & w_b;
      3'b011: w_lane = w_a | w_b;
      3'b100: w_lane = w_a ^ w_b;
      3'b101: w_lane = w_a << w_b[4:0];
      3'b110: w_lane = w_a >> w_b[4:0];
      3'b111: w_lane = w_a * w_b;
      default: w_lane = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_we    <= 1'b0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res_data  <= '0;
      r_dst       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_op       <= bus.op;
            r_a        <= bus.src_a;
            r_b        <= bus.src_b;
            r_dst      <= bus.dst;
            r_res_data <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_res_data[w_lsb +: 32] <= w_lane;
          if (w_last) begin
            r_res_valid <= 1'b1;
            // Scalar register 0 is hardwired zero, so the write is suppressed.
            r_res_we    <= (r_dst != 6'd0);
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_we    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_we    = r_res_we;
  assign bus.res_data  = r_res_data;
  assign bus.res_dst   = r_dst;
endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed self-checking bench for vector_exec_unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_vector_exec_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_XOR = 3'b100,
                         OP_SRL = 3'b110, OP_MUL = 3'b111;

  vector_exec_unit_if #(.LANES(4)) bus ();

  vector_exec_unit #(.LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request in the current (idle) cycle; returns in the first cycle after the accept.
  task automatic issue(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                       input logic [5:0] dst, input string name);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.dst      = dst;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b, expected 1", name, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.src_a    = {$urandom, $urandom, $urandom, $urandom};
    bus.src_b    = {$urandom, $urandom, $urandom, $urandom};
    bus.dst      = 6'($urandom);
  endtask

  task automatic wait_valid(input int exp_lat, input string name);
    int lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== exp_lat || bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (res_valid=%b), expected %0d", name, lat,
               bus.res_valid, exp_lat);
    end
  endtask

  task automatic check_data(input logic [127:0] exp, input string name);
    checks++;
    if (bus.res_data !== exp) begin
      errors++;
      $display("FAIL %s res_data: got %h, expected %h", name, bus.res_data, exp);
    end
  endtask

  // Called in DONE with res_ready = 1; the block must be idle again one cycle later.
  task automatic finish_result(input string name);
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s return to idle: got res_valid=%b in_ready=%b, expected 0/1", name,
               bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b, expected 1", bus.in_ready); end
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid: got %b, expected 0", bus.res_valid); end
    if (bus.res_we !== 1'b0) begin errors++; $display("FAIL reset res_we: got %b, expected 0", bus.res_we); end
    if (bus.res_data !== 128'd0) begin errors++; $display("FAIL reset res_data: got %h, expected 0", bus.res_data); end
    if (bus.res_dst !== 6'd0) begin errors++; $display("FAIL reset res_dst: got %h, expected 0", bus.res_dst); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector_add();
    bus.res_ready = 1'b1;
    issue(OP_ADD, {4{32'hFFFFFFFF}}, {4{32'h00000001}}, 6'h21, "vadd");
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL vadd in_ready while busy: got %b, expected 0", bus.in_ready); end
    wait_valid(5, "vadd");
    check_data(128'd0, "vadd");
    checks += 2;
    if (bus.res_dst !== 6'h21) begin errors++; $display("FAIL vadd res_dst: got %h, expected 21", bus.res_dst); end
    if (bus.res_we !== 1'b1) begin errors++; $display("FAIL vadd res_we: got %b, expected 1", bus.res_we); end
    finish_result("vadd");
  endtask

  task automatic test_scalar_mul();
    issue(OP_MUL, {{96{1'b1}}, 32'h00010000}, {{96{1'b1}}, 32'h00010003}, 6'h05, "smul");
    wait_valid(2, "smul");
    check_data({96'h0, 32'h00030000}, "smul");
    checks++;
    if (bus.res_we !== 1'b1) begin errors++; $display("FAIL smul res_we: got %b, expected 1", bus.res_we); end
    finish_result("smul");
  endtask

  task automatic test_zero_reg();
    issue(OP_XOR, {96'h0, 32'h00000F0F}, {96'h0, 32'h000000FF}, 6'h00, "xor_r0");
    wait_valid(2, "xor_r0");
    check_data({96'h0, 32'h00000FF0}, "xor_r0");
    checks++;
    if (bus.res_we !== 1'b0) begin errors++; $display("FAIL xor_r0 res_we: got %b, expected 0", bus.res_we); end
    finish_result("xor_r0");
  endtask

  task automatic test_all_ops();
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp_tab [8];
    a = {32'h12345678, 32'hF0000001, 32'h00000005, 32'hFFFFFFFF};
    b = {32'h00000004, 32'h0000001F, 32'h00000003, 32'h00000021};
    exp_tab[0] = {32'h1234567C, 32'hF0000020, 32'h00000008, 32'h00000020};
    exp_tab[1] = {32'h12345674, 32'hEFFFFFE2, 32'h00000002, 32'hFFFFFFDE};
    exp_tab[2] = {32'h00000000, 32'h00000001, 32'h00000001, 32'h00000021};
    exp_tab[3] = {32'h1234567C, 32'hF000001F, 32'h00000007, 32'hFFFFFFFF};
    exp_tab[4] = {32'h1234567C, 32'hF000001E, 32'h00000006, 32'hFFFFFFDE};
    exp_tab[5] = {32'h23456780, 32'h80000000, 32'h00000028, 32'hFFFFFFFE};
    exp_tab[6] = {32'h01234567, 32'h00000001, 32'h00000000, 32'h7FFFFFFF};
    exp_tab[7] = {32'h48D159E0, 32'h1000001F, 32'h0000000F, 32'hFFFFFFDF};
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), a, b, 6'h2A, $sformatf("vop%0d", i));
      wait_valid(5, $sformatf("vop%0d", i));
      check_data(exp_tab[i], $sformatf("vop%0d", i));
      finish_result($sformatf("vop%0d", i));
    end
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    issue(OP_SRL, {4{32'h80000000}}, {4{32'd31}}, 6'h30, "bp");
    wait_valid(5, "bp");
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.src_a    = {96'h0, 32'd1};
        bus.src_b    = {96'h0, 32'd2};
        bus.dst      = 6'h02;
      end
      checks++;
      if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_data !== {4{32'h00000001}} ||
          bus.res_dst !== 6'h30 || bus.res_we !== 1'b1) begin
        errors++;
        $display("FAIL bp hold cycle %0d: got valid=%b ready=%b data=%h dst=%h we=%b, expected 1/0/%h/30/1",
                 c, bus.res_valid, bus.in_ready, bus.res_data, bus.res_dst, bus.res_we,
                 {4{32'h00000001}});
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp after handshake: got res_valid=%b in_ready=%b, expected 0/1",
               bus.res_valid, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp next accept: got in_ready=%b, expected 0", bus.in_ready);
    end
    wait_valid(2, "bp_next");
    check_data({96'h0, 32'h00000003}, "bp_next");
    finish_result("bp_next");
  endtask

  task automatic test_reset_mid();
    issue(OP_ADD, {4{32'h11111111}}, {4{32'h22222222}}, 6'h22, "rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 128'd0 || bus.in_ready !== 1'b1 ||
        bus.res_dst !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid state: got valid=%b data=%h ready=%b dst=%h, expected 0/0/1/0",
               bus.res_valid, bus.res_data, bus.in_ready, bus.res_dst);
    end
    issue(OP_ADD, {96'h0, 32'd3}, {96'h0, 32'd4}, 6'h03, "rst_add");
    wait_valid(2, "rst_add");
    check_data({96'h0, 32'h00000007}, "rst_add");
    finish_result("rst_add");
  endtask

  task automatic test_back_to_back();
    int t_res [2];
    int n_res = 0;
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_SUB;
    bus.src_a     = {4{32'h00000000}};
    bus.src_b     = {4{32'h00000001}};
    bus.dst       = 6'h25;
    for (int n = 0; n < 30 && n_res < 2; n++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        t_res[n_res] = n;
        n_res++;
        check_data({4{32'hFFFFFFFF}}, $sformatf("b2b%0d", n_res));
        if (n_res == 2) bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (n_res !== 2 || (t_res[1] - t_res[0]) !== 6) begin
      errors++;
      $display("FAIL b2b spacing: got %0d results, spacing %0d, expected 2 results spaced 6",
               n_res, (n_res == 2) ? (t_res[1] - t_res[0]) : -1);
    end
    bus.in_valid = 1'b0;
    finish_result("b2b");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.dst       = 6'd0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_vector_add();
    test_scalar_mul();
    test_zero_reg();
    test_all_ops();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 Parameter: LANES, default 4, number of 32-bit lanes per vector operand; only 4 is legal.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
REQ-008 src_a  input  128  operand A, from register-file read port 1.
REQ-009 src_b  input  128  operand B, from register-file read port 2.
REQ-010 dst  input  6  destination register address; bit 5 = 1 selects a vector register, bit 5 = 0 selects a scalar register.
REQ-011 res_valid  output  1  result valid.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 res_data  output  128  result data for the register-file write port.
REQ-014 res_dst  output  6  registered copy of dst.
REQ-015 res_we  output  1  write enable for the register file.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and DONE; in_ready = 1 only in IDLE.
REQ-017 In IDLE, when in_valid && in_ready, the block SHALL capture op, src_a, src_b and dst, clear res_data, set the lane counter to 0 and enter BUSY.
REQ-018 In BUSY the block SHALL compute exactly one 32-bit lane per cycle, at lane index = counter, and write it into res_data[32*i+31:32*i].
REQ-019 Vector request (dst[5] = 1): BUSY SHALL last 4 cycles, covering lanes 0 to 3, then the FSM enters DONE.
REQ-020 Scalar request (dst[5] = 0): BUSY SHALL last 1 cycle, covering lane 0 only; res_data[127:32] SHALL stay 0.
REQ-021 Latency from the accept edge to res_valid = 1 SHALL be 5 cycles for a vector request and 2 cycles for a scalar request.
REQ-022 Lane arithmetic SHALL be modulo 2^32, with no carry or borrow between lanes.
REQ-023 MUL SHALL return the low 32 bits of the unsigned product.
REQ-024 SLL and SRL SHALL use shift amount = B lane bits [4:0]; SRL SHALL be a logical shift that fills with zeros.
REQ-025 In DONE, res_valid = 1; res_data, res_dst and res_we SHALL hold stable until res_valid && res_ready.
REQ-026 On res_valid && res_ready, the FSM SHALL return to IDLE.
REQ-027 A new request SHALL NOT be accepted in the same cycle as the result handshake; the earliest new accept is the following cycle.
REQ-028 res_we SHALL be 1 in DONE unless res_dst == 6'b000000, which is scalar register 0 and hardwired zero; in that case res_we = 0 and res_valid is still asserted.
REQ-029 res_we SHALL be 0 whenever res_valid = 0.
REQ-030 in_valid asserted outside IDLE SHALL be ignored; no state change, no capture.
REQ-031 Changes on src_a, src_b, op and dst after the accept edge SHALL NOT affect the result.
REQ-032 res_ready held at 1 before DONE SHALL have no effect.

Reset
REQ-033 On rst = 1 at a clock edge: FSM goes to IDLE, lane counter = 0, res_valid = 0, res_we = 0, res_data = 0, res_dst = 0, in_ready = 1 from the next cycle.
REQ-034 Reset asserted in BUSY or DONE SHALL abort the operation with no result handshake; captured operands are discarded.
REQ-035 rst SHALL take priority over any simultaneous in_valid or res_ready.

Verification
REQ-036 Vector ADD: src_a = {4{32'hFFFFFFFF}}, src_b = {4{32'h00000001}}, dst = 6'h21, res_ready = 1 -> res_valid exactly 5 cycles after accept; res_data = 0 (per-lane wrap, no cross-lane carry); res_dst = 6'h21; res_we = 1.
REQ-037 Scalar MUL: src_a[31:0] = 32'h00010000, src_b[31:0] = 32'h00010003, upper 96 bits of both = all ones, dst = 6'h05 -> result after 2 cycles; res_data = {96'h0, 32'h00030000}.
REQ-038 Write to register 0: scalar XOR with dst = 6'h00 -> res_valid = 1, res_we = 0.
REQ-039 Backpressure: vector SRL with src_a lanes = 32'h80000000, src_b lanes = 32'd31, res_ready = 0 for 10 cycles -> res_valid held at 1; each lane = 32'h00000001 and stable throughout; in_ready = 0; a new in_valid is ignored; after res_ready = 1 the next request is accepted only in the following cycle.
REQ-040 Reset mid-operation: rst pulsed in the 2nd BUSY cycle of a vector op -> next cycle res_valid = 0, res_data = 0, in_ready = 1; a following scalar ADD 3 + 4 returns 32'h00000007.
REQ-041 Back-to-back: two vector SUB ops with in_valid and res_ready held at 1 -> results spaced 6 cycles apart; each lane 32'h00000000 - 32'h00000001 = 32'hFFFFFFFF.
